// File: rtl/smc_seq_ctrl.sv
// smc_seq_ctrl: serial MOSFET ID/gm evaluator feeding descending sorted banks,
// followed by a two-cycle mode-weighted sum presented with a one-cycle out_valid_o.
module smc_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  input  logic [1:0] mode_i,
  input  logic [2:0] w_i,
  input  logic [2:0] v_gs_i,
  input  logic [2:0] v_ds_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [9:0] out_n_o
);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            ph_q, ph_d;
  logic [5:0][7:0] id_q, id_d, gm_q, gm_d, id_b, gm_b, id_ins, gm_ins;
  logic [2:0][7:0] sid_q, sid_d, sgm_q, sgm_d;
  logic [9:0]      out_n_q, out_n_d, sum;
  logic [9:0]      w10, vds, vov, id_num, gm_num;
  logic [7:0]      id_new, gm_new;
  logic            cut, triode, accept;
  assign in_ready_o  = (state_q == IDLE) || (state_q == LOAD);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = state_q == OUT;
  assign out_n_o     = out_n_q;
  always_comb begin
    w10    = {7'd0, w_i};
    vds    = {7'd0, v_ds_i};
    vov    = {7'd0, v_gs_i} - 10'd1;
    cut    = v_gs_i == 3'd0;
    triode = !cut && (vov > vds);
    id_num = cut ? 10'd0 : triode ? (10'd2 * vov - vds) * w10 * vds : w10 * vov * vov;
    gm_num = cut ? 10'd0 : 10'd2 * w10 * (triode ? vds : vov);
    id_new = 8'(id_num / 10'd3);
    gm_new = 8'(gm_num / 10'd3);
  end
  // IDLE presents empty banks so the first accepted transistor lands in a cleared bank
  assign id_b = (state_q == IDLE) ? '0 : id_q;
  assign gm_b = (state_q == IDLE) ? '0 : gm_q;
  for (genvar i = 0; i < 6; i++) begin : g_ins
    if (i == 0) begin : g_head
      assign id_ins[0] = (id_b[0] >= id_new) ? id_b[0] : id_new;
      assign gm_ins[0] = (gm_b[0] >= gm_new) ? gm_b[0] : gm_new;
    end else begin : g_tail
      assign id_ins[i] = (id_b[i] >= id_new) ? id_b[i] : (id_b[i-1] >= id_new) ? id_new : id_b[i-1];
      assign gm_ins[i] = (gm_b[i] >= gm_new) ? gm_b[i] : (gm_b[i-1] >= gm_new) ? gm_new : gm_b[i-1];
    end
  end
  assign id_d = accept ? id_ins : id_b;
  assign gm_d = accept ? gm_ins : gm_b;
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sid_d[k] = mode_q[1] ? id_q[k] : id_q[k+3];
      sgm_d[k] = mode_q[1] ? gm_q[k] : gm_q[k+3];
    end
    sum = mode_q[0] ? 10'd3 * {2'd0, sid_q[0]} + 10'd4 * {2'd0, sid_q[1]} + 10'd5 * {2'd0, sid_q[2]}
                    : {2'd0, sgm_q[0]} + {2'd0, sgm_q[1]} + {2'd0, sgm_q[2]};
  end
  // CALC spans two cycles: selection is registered, then the weighted sum
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ph_d    = 1'b0;
    out_n_d = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid_i) begin
          mode_d  = mode_i;
          state_d = LOAD;
        end
      end
      LOAD: if (in_valid_i) begin
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd4) ? CALC : LOAD;
      end
      CALC: begin
        ph_d = !ph_q;
        if (ph_q) begin
          state_d = OUT;
          out_n_d = sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      ph_q    <= 1'b0;
      id_q    <= '0;
      gm_q    <= '0;
      sid_q   <= '0;
      sgm_q   <= '0;
      out_n_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ph_q    <= ph_d;
      id_q    <= id_d;
      gm_q    <= gm_d;
      sid_q   <= sid_d;
      sgm_q   <= sgm_d;
      out_n_q <= out_n_d;
    end
  end
endmodule

// File: tb/tb_smc_seq_ctrl.sv
// tb_smc_seq_ctrl: table vectors from the documented cases plus random bursts
// checked against a sort-based reference model.
module tb_smc_seq_ctrl;
  logic       clk, rst_n, in_valid;
  logic [1:0] mode;
  logic [2:0] w, vgs, vds;
  logic       in_ready, out_valid;
  logic [9:0] out_n;
  int total = 0, bad = 0, cyc = 0, p1 = 0, p2 = 0;

  typedef struct {
    logic [1:0]      mode;
    logic [5:0][2:0] w, g, d;
    int              exp;
  } vec_t;

  localparam logic [5:0][2:0] MX_W = {3'd6, 3'd1, 3'd3, 3'd3, 3'd1, 3'd7};
  localparam logic [5:0][2:0] MX_G = {3'd3, 3'd2, 3'd7, 3'd4, 3'd1, 3'd7};
  localparam logic [5:0][2:0] MX_D = {3'd5, 3'd1, 3'd2, 3'd7, 3'd3, 3'd7};

  smc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .mode_i(mode),
    .w_i(w), .v_gs_i(vgs), .v_ds_i(vds),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_n_o(out_n)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && out_valid === 1'b0) chk("out_n_idle", 32'(out_n), 0);

  function automatic int ev_id(input int ww, input int g, input int d);
    int ov = g - 1;
    if (g == 0) return 0;
    return (ov > d) ? ((2 * ov - d) * ww * d) / 3 : (ww * ov * ov) / 3;
  endfunction

  function automatic int ev_gm(input int ww, input int g, input int d);
    int ov = g - 1;
    if (g == 0) return 0;
    return (ov > d) ? (2 * ww * d) / 3 : (2 * ww * ov) / 3;
  endfunction

  function automatic int model(input vec_t v);
    int ids[$], gms[$], b;
    for (int k = 0; k < 6; k++) begin
      ids.push_back(ev_id(int'(v.w[k]), int'(v.g[k]), int'(v.d[k])));
      gms.push_back(ev_gm(int'(v.w[k]), int'(v.g[k]), int'(v.d[k])));
    end
    ids.rsort();
    gms.rsort();
    b = v.mode[1] ? 0 : 3;
    return v.mode[0] ? 3 * ids[b] + 4 * ids[b+1] + 5 * ids[b+2] : gms[b] + gms[b+1] + gms[b+2];
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input logic [5:0][2:0] ww, g, d, input int e);
    vec_t v;
    v.mode = m; v.w = ww; v.g = g; v.d = d; v.exp = e;
    return v;
  endfunction

  task automatic send(input vec_t v, input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      if (maxgap > 0 && k > 0) begin
        in_valid = 0;
        w = 3'($urandom); vgs = 3'($urandom); vds = 3'($urandom);
        repeat ($urandom_range(maxgap, 1)) @(negedge clk);
      end
      in_valid = 1;
      mode = (k == 0) ? v.mode : 2'($urandom);
      w = v.w[k]; vgs = v.g[k]; vds = v.d[k];
      chk("in_ready_load", 32'(in_ready), 1);
      @(negedge clk);
    end
  endtask

  task automatic wait_pulse(input int exp, input string nm, input bit hold, output int pc);
    int n = 0;
    in_valid = hold;
    while (out_valid !== 1'b1 && n < 20) begin
      chk("in_ready_busy", 32'(in_ready), 0);
      if (hold) begin
        mode = 2'($urandom); w = 3'($urandom); vgs = 3'($urandom); vds = 3'($urandom);
      end
      @(negedge clk);
      n++;
    end
    in_valid = 0;
    pc = cyc;
    chk({nm, "_pulse"}, 32'(out_valid), 1);
    chk({nm, "_latency"}, 32'(n), 2);
    chk(nm, 32'(out_n), 32'(exp));
    @(negedge clk);
    chk({nm, "_width"}, 32'(out_valid), 0);
    chk({nm, "_ready_back"}, 32'(in_ready), 1);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t rv;
    int pc;
    tbl[0] = mk(2'b11, {6{3'd3}}, {6{3'd4}}, {6{3'd7}}, 108);
    tbl[1] = mk(2'b10, {6{3'd3}}, {6{3'd4}}, {6{3'd7}}, 18);
    tbl[2] = mk(2'b11, {6{3'd3}}, {6{3'd7}}, {6{3'd2}}, 240);
    tbl[3] = mk(2'b00, {6{3'd3}}, {6{3'd7}}, {6{3'd2}}, 12);
    tbl[4] = mk(2'b11, MX_W, MX_G, MX_D, 377);
    tbl[5] = mk(2'b01, MX_W, MX_G, MX_D, 24);
    tbl[6] = mk(2'b10, MX_W, MX_G, MX_D, 42);
    tbl[7] = mk(2'b00, MX_W, MX_G, MX_D, 4);
    rst_n = 0; in_valid = 0; mode = 0; w = 0; vgs = 0; vds = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_n", 32'(out_n), 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      send(tbl[i], 6, 0);
      wait_pulse(tbl[i].exp, $sformatf("table%0d", i), 0, pc);
    end
    send(tbl[4], 6, 3);
    wait_pulse(377, "gaps_hold", 1, pc);
    send(tbl[7], 6, 0);
    wait_pulse(4, "after_hold", 0, pc);
    send(tbl[7], 3, 0);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_n", 32'(out_n), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send(tbl[0], 6, 0);
    wait_pulse(108, "post_reset", 0, pc);
    send(tbl[0], 6, 0);
    wait_pulse(108, "b2b_first", 0, p1);
    send(tbl[2], 6, 0);
    wait_pulse(240, "b2b_second", 0, p2);
    chk("b2b_spacing", 32'(p2 - p1), 9);
    for (int i = 0; i < 24; i++) begin
      rv.mode = 2'($urandom);
      for (int k = 0; k < 6; k++) begin
        rv.w[k] = 3'($urandom); rv.g[k] = 3'($urandom); rv.d[k] = 3'($urandom);
      end
      rv.exp = model(rv);
      send(rv, 6, $urandom_range(3, 0));
      wait_pulse(rv.exp, $sformatf("rand%0d", i), 1'($urandom), pc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
